game_controller: RTL and testbench

//  Control FSM for the memory game: consumes the datapath status flags
//  (end_FPGA, end_User, end_time, win, match) and drives its control inputs
//  (R1, R2, E1..E4, SEL). Also conditions the player's ENTER push-button
//  (sync + debounce + edge). Sits beside datapath in the top level.

---
 rtl/game_defs_pkg.sv | 18 +
 rtl/game_controller_button_cond.sv | 54 +++++
 rtl/game_controller.sv | 132 +++++++++++++
 tb/tb_game_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_defs_pkg.sv
// rtl/game_defs_pkg.sv - shared state encoding for the memory game controller and datapath
package game_defs;

  localparam int STATE_W = 3;

  // Codes double as the STATE debug output; RESULT shares S_INIT's code.
  typedef enum logic [STATE_W-1:0] {
    S_INIT   = 3'd0,
    S_SETUP  = 3'd1,
    S_PREP   = 3'd2,
    S_SHOW   = 3'd3,
    S_PLAY   = 3'd4,
    S_CHECK  = 3'd5,
    S_NEXT   = 3'd6,
    S_SETTLE = 3'd7
  } state_e;

endpackage

// File: rtl/game_controller_button_cond.sv
// rtl/game_controller_button_cond.sv - ENTER push-button synchroniser, debouncer and press detector
module button_cond #(
  parameter int P_DEBOUNCE = 500000
) (
  input  logic CLOCK_50,
  input  logic R,
  input  logic btn_n,
  output logic press_p
);

  localparam int CNT_W = (P_DEBOUNCE > 1) ? $clog2(P_DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_DEBOUNCE - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Two-flop synchroniser plus debounce registers; idle level of the button is 1 (released).
  always_ff @(posedge CLOCK_50) begin
    if (R) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  // Count consecutive samples that disagree with the stable level; adopt the new level
  // on the P_DEBOUNCE-th one and pulse only when it is a press (1 -> 0).
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        press_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign press_p = press_q;

endmodule

// File: rtl/game_controller.sv
// rtl/game_controller.sv - control FSM of the memory game with conditioned ENTER button
module game_controller
  import game_defs::*;
#(
  parameter int p_key      = 4,
  parameter int P_ENTER    = 1,
  parameter int P_DEBOUNCE = 500000
) (
  input  logic               CLOCK_50,
  input  logic               R,
  input  logic [p_key-1:0]   KEY,
  input  logic               end_FPGA,
  input  logic               end_User,
  input  logic               end_time,
  input  logic               win,
  input  logic               match,
  output logic               R1,
  output logic               R2,
  output logic               E1,
  output logic               E2,
  output logic               E3,
  output logic               E4,
  output logic               SEL,
  output logic [STATE_W-1:0] STATE
);

  logic   enter_p;
  state_e state_q, state_d;
  logic   done_q, done_d;

  // Only the ENTER key is used here; the remaining buttons belong to other blocks.
  logic unused_keys;
  assign unused_keys = ^KEY;

  button_cond #(
    .P_DEBOUNCE (P_DEBOUNCE)
  ) u_enter (
    .CLOCK_50 (CLOCK_50),
    .R        (R),
    .btn_n    (KEY[P_ENTER]),
    .press_p  (enter_p)
  );

  // State register; done_q marks RESULT, which sits on the INIT code.
  always_ff @(posedge CLOCK_50) begin
    if (R) begin
      state_q <= S_INIT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic and Moore output decode of the registered state.
  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    R1      = 1'b0;
    R2      = 1'b0;
    E1      = 1'b0;
    E2      = 1'b0;
    E3      = 1'b0;
    E4      = 1'b0;
    SEL     = 1'b0;
    STATE   = state_q;

    if (done_q) begin
      STATE = S_INIT;
      if (enter_p) begin
        done_d  = 1'b0;
        state_d = S_INIT;
      end
    end else begin
      SEL = 1'b1;
      case (state_q)
        S_INIT: begin
          R1      = 1'b1;
          R2      = 1'b1;
          state_d = S_SETUP;
        end
        S_SETUP: begin
          E1 = 1'b1;
          if (enter_p) state_d = S_PREP;
        end
        S_PREP: begin
          R2      = 1'b1;
          state_d = S_SHOW;
        end
        S_SHOW: begin
          E3 = 1'b1;
          if (end_FPGA) state_d = S_PLAY;
        end
        S_PLAY: begin
          E2 = 1'b1;
          // Timeout has priority over a simultaneous end of entry.
          if (end_time) begin
            state_d = S_INIT;
            done_d  = 1'b1;
          end else if (end_User) begin
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (match) begin
            state_d = S_NEXT;
          end else begin
            state_d = S_INIT;
            done_d  = 1'b1;
          end
        end
        S_NEXT: begin
          E4      = 1'b1;
          state_d = S_SETTLE;
        end
        S_SETTLE: begin
          // win reflects the incremented round counter only from this cycle on.
          if (win) begin
            state_d = S_INIT;
            done_d  = 1'b1;
          end else begin
            state_d = S_PREP;
          end
        end
        default: begin
          state_d = S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// tb/tb_game_controller.sv - self-checking bench for game_controller with a behavioural model
module tb_game_controller;

  localparam int DEB = 4;

  logic       CLOCK_50 = 1'b0;
  logic       R;
  logic [3:0] KEY;
  logic       end_FPGA, end_User, end_time, win, match;
  logic       R1, R2, E1, E2, E3, E4, SEL;
  logic [2:0] STATE;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: states 0..7 as in the table, 8 = RESULT.
  int m_state = 0;
  bit m_press = 1'b0;
  bit m_stable = 1'b1;
  bit m_dly[$];
  bit m_hist[$];
  bit check_en = 1'b0;

  always #5 CLOCK_50 = ~CLOCK_50;

  game_controller #(
    .p_key      (4),
    .P_ENTER    (1),
    .P_DEBOUNCE (DEB)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .R        (R),
    .KEY      (KEY),
    .end_FPGA (end_FPGA),
    .end_User (end_User),
    .end_time (end_time),
    .win      (win),
    .match    (match),
    .R1       (R1),
    .R2       (R2),
    .E1       (E1),
    .E2       (E2),
    .E3       (E3),
    .E4       (E4),
    .SEL      (SEL),
    .STATE    (STATE)
  );

  function automatic int model_next(int st, bit p, bit ef, bit eu, bit et, bit w, bit m);
    case (st)
      0: return 1;
      1: return p ? 2 : 1;
      2: return 3;
      3: return ef ? 4 : 3;
      4: return et ? 8 : (eu ? 5 : 4);
      5: return m ? 6 : 8;
      6: return 7;
      7: return w ? 8 : 2;
      8: return p ? 0 : 8;
      default: return 0;
    endcase
  endfunction

  // {R1,R2,E1,E2,E3,E4,SEL,STATE}
  function automatic logic [9:0] exp_vec(int st);
    logic [6:0] ctl;
    case (st)
      0: ctl = 7'b1100001;
      1: ctl = 7'b0010001;
      2: ctl = 7'b0100001;
      3: ctl = 7'b0000101;
      4: ctl = 7'b0001001;
      5: ctl = 7'b0000001;
      6: ctl = 7'b0000011;
      7: ctl = 7'b0000001;
      default: ctl = 7'b0000000;
    endcase
    return {ctl, (st == 8) ? 3'd0 : 3'(st)};
  endfunction

  always @(posedge CLOCK_50) begin
    bit s;
    bit np;
    if (R) begin
      m_state  = 0;
      m_press  = 1'b0;
      m_stable = 1'b1;
      m_dly    = '{1'b1, 1'b1};
      m_hist.delete();
      check_en = 1'b1;
    end else begin
      m_state = model_next(m_state, m_press, end_FPGA, end_User, end_time, win, match);
      s = m_dly.pop_front();
      m_dly.push_back(KEY[1]);
      if (s != m_stable) m_hist.push_back(s);
      else m_hist.delete();
      np = 1'b0;
      if (m_hist.size() == DEB) begin
        m_stable = s;
        np = (s == 1'b0);
        m_hist.delete();
      end
      m_press = np;
    end
  end

  always @(negedge CLOCK_50) begin
    logic [9:0] got, exp;
    if (check_en) begin
      exp = exp_vec(m_state);
      got = {R1, R2, E1, E2, E3, E4, SEL, STATE};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL cycle_outputs t=%0t: got %b required %b (model state %0d)", $time, got, exp, m_state);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #2;
    end
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end
  endtask

  task automatic press_hold(int hold, int rel);
    KEY[1] = 1'b0;
    tick(hold);
    KEY[1] = 1'b1;
    tick(rel);
  endtask

  initial begin
    int prep_cnt;
    int prep_h;
    int init_cnt;
    int run;
    bit key1;

    R = 1'b1; KEY = 4'hF;
    end_FPGA = 1'b0; end_User = 1'b0; end_time = 1'b0; win = 1'b0; match = 1'b0;

    // 1: reset then SETUP
    tick(2);
    chk("rst_R1", R1, 1); chk("rst_R2", R2, 1); chk("rst_SEL", SEL, 1);
    chk("rst_E1", E1, 0); chk("rst_STATE", STATE, 0);
    R = 1'b0;
    tick(1);
    chk("setup_E1", E1, 1); chk("setup_STATE", STATE, 1);

    // 2: bouncing ENTER then a held press
    for (int i = 0; i < 5; i++) begin
      KEY[1] = (i % 2 == 1);
      tick(1);
    end
    prep_cnt = 0; prep_h = 0;
    for (int h = 1; h <= 8; h++) begin
      tick(1);
      if (STATE == 3'd2) begin
        prep_cnt++;
        prep_h = h;
      end
    end
    chk("bounce_prep_count", prep_cnt, 1);
    chk("bounce_prep_delay", prep_h, 6);
    chk("bounce_show_STATE", STATE, 3);
    chk("model_show", m_state, 3);
    KEY[1] = 1'b1;
    tick(8);

    // 3: a passed round returning to PREP
    end_FPGA = 1'b1; tick(1); end_FPGA = 1'b0;
    chk("play_E2", E2, 1);
    end_User = 1'b1; match = 1'b1; tick(1);
    chk("check_STATE", STATE, 5);
    tick(1);
    chk("next_E4", E4, 1);
    end_User = 1'b0;
    tick(1);
    chk("settle_E4", E4, 0); chk("settle_STATE", STATE, 7);
    tick(1);
    chk("again_prep_R2", R2, 1); chk("again_prep_STATE", STATE, 2);
    tick(1);

    // 4: timeout and end of entry together -> loss
    end_FPGA = 1'b1; tick(1); end_FPGA = 1'b0;
    end_time = 1'b1; end_User = 1'b1; tick(1);
    end_time = 1'b0; end_User = 1'b0;
    chk("result_SEL", SEL, 0); chk("result_E2", E2, 0);
    chk("result_R1", R1, 0); chk("result_STATE", STATE, 0);
    press_hold(8, 8);
    chk("restart_STATE", STATE, 1);

    // 5a: mismatch -> RESULT
    press_hold(8, 8);
    chk("show2_STATE", STATE, 3);
    end_FPGA = 1'b1; tick(1); end_FPGA = 1'b0;
    end_User = 1'b1; match = 1'b0; tick(2); end_User = 1'b0;
    chk("mismatch_SEL", SEL, 0); chk("mismatch_R1", R1, 0);

    // 5b: a long hold gives a single press
    KEY[1] = 1'b0;
    init_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (R1 === 1'b1) init_cnt++;
    end
    chk("long_hold_init_count", init_cnt, 1);
    chk("long_hold_STATE", STATE, 1);
    KEY[1] = 1'b1;
    tick(8);

    // 5c: final round won
    press_hold(8, 8);
    end_FPGA = 1'b1; tick(1); end_FPGA = 1'b0;
    end_User = 1'b1; match = 1'b1; tick(1); end_User = 1'b0;
    tick(1);
    win = 1'b1; tick(2); win = 1'b0;
    chk("win_SEL", SEL, 0); chk("win_STATE", STATE, 0);

    // 6: reset mid-round with ENTER partly debounced
    press_hold(8, 8);
    press_hold(8, 8);
    end_FPGA = 1'b1; tick(1); end_FPGA = 1'b0;
    chk("pre_reset_E2", E2, 1);
    KEY[1] = 1'b0;
    tick(2);
    R = 1'b1; tick(1);
    chk("midreset_R1", R1, 1); chk("midreset_R2", R2, 1);
    chk("midreset_E2", E2, 0); chk("midreset_STATE", STATE, 0);
    R = 1'b0;
    tick(6);
    chk("postreset_setup", STATE, 1);
    tick(1);
    chk("postreset_prep", STATE, 2);
    KEY[1] = 1'b1;
    tick(8);

    // Random phase against the model
    key1 = 1'b1; run = 0;
    for (int c = 0; c < 4000; c++) begin
      if (run == 0) begin
        key1 = ~key1;
        run = $urandom_range(1, 12);
      end
      run--;
      KEY      = 4'($urandom);
      KEY[1]   = key1;
      R        = ($urandom_range(0, 299) == 0);
      end_FPGA = ($urandom_range(0, 3) == 0);
      end_User = ($urandom_range(0, 3) == 0);
      end_time = ($urandom_range(0, 7) == 0);
      win      = 1'($urandom_range(0, 1));
      match    = ($urandom_range(0, 2) != 0);
      tick(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
